array_stream_loader: RTL

- Serial-to-parallel array loader: accepts one WIDTH-bit element per valid/ready beat and writes it into a DEPTH-entry array at a running index.
- Presents the completed array as one parallel word.
- Drives combinational consumers that read the array by index in generate loops; the write side fills entries one per cycle.
- Sits between a streaming producer and array-consuming datapath logic in the same clock domain.

---
 rtl/array_stream_loader_if.sv | 30 +++
 rtl/array_stream_loader.sv | 103 ++++++++++
 2 files changed

// File: rtl/array_stream_loader_if.sv
// Stream-in / array-out bundle for array_stream_loader.
// The producer and consumer side takes the master modport.
// The loader takes the slave modport.
interface array_stream_loader_if #(
  parameter int DEPTH = 10,
  parameter int WIDTH = 32
);
  localparam int IDX_W = $clog2(DEPTH + 1);

  logic                     in_valid;
  logic                     in_ready;
  logic [WIDTH-1:0]         in_data;
  logic                     in_last;
  logic                     flush;
  logic                     out_valid;
  logic                     out_ready;
  logic [DEPTH*WIDTH-1:0]   out_data;
  logic [IDX_W-1:0]         out_count;
  logic [IDX_W-1:0]         fill_idx;

  modport master (
    output in_valid, in_data, in_last, flush, out_ready,
    input  in_ready, out_valid, out_data, out_count, fill_idx
  );

  modport slave (
    input  in_valid, in_data, in_last, flush, out_ready,
    output in_ready, out_valid, out_data, out_count, fill_idx
  );
endinterface

// File: rtl/array_stream_loader.sv
// Serial-to-parallel array loader.
// Each accepted element goes into a DEPTH-entry array at a running index.
// A frame is presented when the array is full, or when an element arrives with in_last.
// The presented frame is held until the consumer takes it.
// All entries are cleared on handoff, so the unused tail of a short frame reads as zero.
module array_stream_loader #(
  parameter  int DEPTH = 10,
  parameter  int WIDTH = 32,
  localparam int IDX_W = $clog2(DEPTH + 1)
) (
  input logic                  clk,
  input logic                  rst,
  array_stream_loader_if.slave bus
);

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  state_t                 state_r;
  logic [IDX_W-1:0]       fill_idx_r;
  logic [IDX_W-1:0]       out_count_r;
  logic [DEPTH*WIDTH-1:0] data_r;
  logic                   in_ready_r;
  logic                   out_valid_r;

  // Accept is only ever possible in FILL.
  // in_ready_r mirrors that state, so it qualifies the write directly.
  logic accept_s;
  assign accept_s = bus.in_valid && in_ready_r;

  // Frame FSM.
  // It updates the array storage, the index and count, and the registered handshake flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_FILL;
      fill_idx_r  <= '0;
      out_count_r <= '0;
      data_r      <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_FILL: begin
          if (bus.flush) begin
            // Abort of a partial frame.
            // Flush wins over a simultaneous accept.
            fill_idx_r <= '0;
            data_r     <= '0;
          end else if (accept_s) begin
            // Index compare per entry keeps every write inside the array.
            for (int k = 0; k < DEPTH; k++) begin
              if (fill_idx_r == IDX_W'(k)) begin
                data_r[k*WIDTH +: WIDTH] <= bus.in_data;
              end
            end
            if ((fill_idx_r == LAST_IDX) || bus.in_last) begin
              out_count_r <= fill_idx_r + IDX_W'(1);
              fill_idx_r  <= '0;
              state_r     <= ST_FULL;
              in_ready_r  <= 1'b0;
              out_valid_r <= 1'b1;
            end else begin
              fill_idx_r <= fill_idx_r + IDX_W'(1);
            end
          end else begin
            fill_idx_r <= fill_idx_r;
          end
        end
        ST_FULL: begin
          // Flush is ignored here; only the consumer handshake releases the frame.
          if (out_valid_r && bus.out_ready) begin
            data_r      <= '0;
            out_count_r <= '0;
            state_r     <= ST_FILL;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
          end else begin
            state_r <= ST_FULL;
          end
        end
        default: begin
          state_r     <= ST_FILL;
          fill_idx_r  <= '0;
          out_count_r <= '0;
          data_r      <= '0;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = data_r;
  assign bus.out_count = out_count_r;
  assign bus.fill_idx  = fill_idx_r;

endmodule
